wb_mem_arbiter: RTL and testbench
=================================

// Module: wb_mem_arbiter
// PURPOSE
//  Two-master Wishbone arbiter that shares one mem instance between the core (load/store port) and the UART bridge.
//  Replaces the fixed select-pin mux with registered grants, a core stall on contention, and per-master ack routing.
//  One instance sits in front of the data memory and another in front of the instruction memory.
// PARAMETERS
//  DATA_WIDTH      32   data bus width
//  ADDR_WIDTH      32   master address width; slave address is truncated to MEM_ADDR_W
//  MEM_ADDR_W      10   address bits driven to mem
//  TIMEOUT_CYCLES  16   cycles without ack before abort (used only with WB_ARB_TIMEOUT_EN)
// PORTS
//  clk           in   1            system clock
//  rst           in   1            synchronous reset, active-high
//  i_core_req    in   1            core access request, held until o_core_ack
//  i_core_we     in   1            core write enable
//  i_core_adr    in   ADDR_WIDTH   core address
//  i_core_dat    in   DATA_WIDTH   core write data
//  o_core_dat    out  DATA_WIDTH   read data to core
//  o_core_ack    out  1            core access complete
//  o_core_stall  out  1            core must hold its pipeline
//  i_uart_cyc    in   1            UART bridge Wishbone cycle
//  i_uart_stb    in   1            UART bridge Wishbone strobe
//  i_uart_we     in   1            UART bridge write enable
//  i_uart_adr    in   ADDR_WIDTH   UART bridge address
//  i_uart_dat    in   DATA_WIDTH   UART bridge write data
//  o_uart_dat    out  DATA_WIDTH   read data to UART bridge
//  o_uart_ack    out  1            UART bridge ack
//  o_mem_cyc     out  1            cycle to mem
//  o_mem_stb     out  1            strobe to mem
//  o_mem_we      out  1            write enable to mem
//  o_mem_adr     out  MEM_ADDR_W   address to mem
//  o_mem_dat     out  DATA_WIDTH   write data to mem
//  i_mem_dat     in   DATA_WIDTH   read data from mem
//  i_mem_ack     in   1            ack from mem
//  o_err         out  1            one-cycle pulse on timeout abort
// BEHAVIOUR
//  - Clocking/reset: single clock clk; rst synchronous, active-high.
//  - Reset values: state IDLE, last_grant=UART, all outputs 0 (data buses 0).
//  - FSM states:
//      IDLE: arbitrate on the requests registered this cycle.
//        - only UART (cyc&stb) requesting -> UART_BUSY
//        - only core requesting -> CORE_BUSY
//        - both requesting -> grant the master that is NOT last_grant (round-robin on ties)
//      CORE_BUSY / UART_BUSY: o_mem_* driven from the granted master; o_mem_cyc=o_mem_stb=1.
//        - on i_mem_ack: same-cycle combinational ack and read data to the granted master only; update last_grant; -> IDLE.
//  - Latency: request seen in IDLE at cycle N; mem strobed at N+1; ack at N+2 with the 1-cycle mem.
//    Minimum 2 cycles per access; no back-to-back grants without an IDLE cycle.
//  - Stall: o_core_stall = i_core_req & ~o_core_ack. It is also asserted while UART_BUSY, even with no core request.
//  - Ungranted master: ack=0 and dat=0 every cycle.
//  - UART abort: UART drops cyc while UART_BUSY -> mem cyc/stb deasserted the next cycle, -> IDLE, no ack to UART.
//    The core cannot abort; its request must stay high.
//  - Address: o_mem_adr = granted adr[MEM_ADDR_W-1:0]; upper bits ignored.
//  - rst asserted mid-access: immediate return to IDLE; no ack issued; the pending access is lost.
// CONFIGURATION
//  `WB_ARB_TIMEOUT_EN defined:
//    - A counter runs in the BUSY states and clears in IDLE.
//    - Reaching TIMEOUT_CYCLES with no ack: ack the granted master with dat=0, pulse o_err for 1 cycle, -> IDLE.
//  `WB_ARB_TIMEOUT_EN undefined: the BUSY states wait indefinitely; o_err is tied 0; no counter logic.
// STRUCTURE
//  - Shared package osiris_pkg: state encoding localparams (IDLE=2'd0, CORE_BUSY=2'd1, UART_BUSY=2'd2)
//    and grant encoding (GNT_CORE=1'b0, GNT_UART=1'b1).
//  - One sub-module, wb_timeout_cnt: a clear/enable counter that outputs an expired flag. Instantiated only under the macro.
// TESTING
//  1. Core read only: core req adr=0x10, mem returns 0xDEADBEEF
//     -> o_mem_stb at N+1, o_core_ack + o_core_dat=0xDEADBEEF at N+2, stall low at N+3.
//  2. UART write only: adr=0x3FF, dat=0xA5A5A5A5 -> mem we=1, adr=0x3FF; o_uart_ack 1 cycle; core ack stays 0.
//  3. Simultaneous requests twice after reset -> core granted first (last_grant=UART), then UART;
//     core stalled throughout the UART access.
//  4. UART drops cyc while UART_BUSY before ack -> o_mem_cyc=0 the next cycle, IDLE, o_uart_ack never pulses.
//  5. rst pulsed during CORE_BUSY -> all outputs 0 the next cycle, state IDLE, no ack.
//  6. (WB_ARB_TIMEOUT_EN) mem never acks a core read -> after 16 cycles: o_core_ack=1, dat=0, o_err=1 for 1 cycle.

Source files
------------

// File: rtl/osiris_pkg.sv
// ---------------------------------------------------------------------------
// osiris_pkg
//   Shared definitions for the Wishbone memory arbiter: FSM state encoding and
//   grant encoding used for the round-robin tie-break.
// ---------------------------------------------------------------------------
package osiris_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CORE_BUSY = 2'd1,
    UART_BUSY = 2'd2
  } arb_state_t;

  localparam logic GNT_CORE = 1'b0;
  localparam logic GNT_UART = 1'b1;

endpackage

// File: rtl/wb_timeout_cnt.sv
// ---------------------------------------------------------------------------
// wb_timeout_cnt
//   Clear/enable cycle counter that flags when a bus access has been pending
//   for TIMEOUT_CYCLES cycles. Only instantiated when WB_ARB_TIMEOUT_EN is
//   defined.
// Ports:
//   clk      in  system clock
//   rst      in  synchronous reset, active-high
//   clr      in  synchronous clear (arbiter idle)
//   en       in  count enable (arbiter busy)
//   expired  out high during the TIMEOUT_CYCLES-th enabled cycle
// ---------------------------------------------------------------------------
module wb_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  // Saturates at LAST so a stuck enable can never wrap back to "not expired".
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = en & (count == LAST);

endmodule

// File: rtl/wb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// wb_mem_arbiter
//   Two-master Wishbone arbiter sharing one memory between the core load/store
//   port and the UART bridge. Registered grants, round-robin on ties, core
//   stall on contention, per-master ack/data routing.
//
// Configuration macro:
//   WB_ARB_TIMEOUT_EN  when defined, an access pending TIMEOUT_CYCLES cycles
//                      without i_mem_ack is acked with zero data and o_err
//                      pulses for one cycle. When undefined, busy states wait
//                      indefinitely and o_err is tied low.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   i_core_req/we/adr/dat         core request (held until o_core_ack)
//   o_core_dat/ack/stall          core read data, completion, pipeline stall
//   i_uart_cyc/stb/we/adr/dat     UART bridge Wishbone master
//   o_uart_dat/ack                UART bridge read data, ack
//   o_mem_cyc/stb/we/adr/dat      Wishbone master to memory
//   i_mem_dat/ack                 memory read data, ack
//   o_err                         one-cycle pulse on timeout abort
// ---------------------------------------------------------------------------
module wb_mem_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int MEM_ADDR_W     = 10,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_core_req,
  input  logic                  i_core_we,
  input  logic [ADDR_WIDTH-1:0] i_core_adr,
  input  logic [DATA_WIDTH-1:0] i_core_dat,
  output logic [DATA_WIDTH-1:0] o_core_dat,
  output logic                  o_core_ack,
  output logic                  o_core_stall,
  input  logic                  i_uart_cyc,
  input  logic                  i_uart_stb,
  input  logic                  i_uart_we,
  input  logic [ADDR_WIDTH-1:0] i_uart_adr,
  input  logic [DATA_WIDTH-1:0] i_uart_dat,
  output logic [DATA_WIDTH-1:0] o_uart_dat,
  output logic                  o_uart_ack,
  output logic                  o_mem_cyc,
  output logic                  o_mem_stb,
  output logic                  o_mem_we,
  output logic [MEM_ADDR_W-1:0] o_mem_adr,
  output logic [DATA_WIDTH-1:0] o_mem_dat,
  input  logic [DATA_WIDTH-1:0] i_mem_dat,
  input  logic                  i_mem_ack,
  output logic                  o_err
);

  import osiris_pkg::*;

  arb_state_t state, state_nxt;
  logic       last_grant, last_grant_nxt;
  logic       uart_req, core_busy, uart_busy;
  logic       timeout, done;

  assign uart_req  = i_uart_cyc & i_uart_stb;
  assign core_busy = (state == CORE_BUSY);
  assign uart_busy = (state == UART_BUSY);

`ifdef WB_ARB_TIMEOUT_EN
  logic expired;

  wb_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (state == IDLE),
    .en     (core_busy | uart_busy),
    .expired(expired)
  );

  // A real ack in the expiry cycle wins over the abort.
  assign timeout = expired & ~i_mem_ack;
  assign o_err   = timeout & ~rst;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
  assign o_err   = 1'b0;
`endif

  assign done = i_mem_ack | timeout;

  // Upper master address bits are intentionally dropped.
  logic unused_adr_bits;
  assign unused_adr_bits = ^{i_core_adr[ADDR_WIDTH-1:MEM_ADDR_W],
                             i_uart_adr[ADDR_WIDTH-1:MEM_ADDR_W]};

  // NOTE: every always_comb output gets a default before the case so no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    case (state)
      IDLE: begin
        if (i_core_req && uart_req) begin
          state_nxt = (last_grant == GNT_UART) ? CORE_BUSY : UART_BUSY;
        end else if (i_core_req) begin
          state_nxt = CORE_BUSY;
        end else if (uart_req) begin
          state_nxt = UART_BUSY;
        end
      end
      CORE_BUSY: begin
        if (done) begin
          state_nxt      = IDLE;
          last_grant_nxt = GNT_CORE;
        end
      end
      UART_BUSY: begin
        // Dropping cyc abandons the access without an ack or grant update.
        if (!i_uart_cyc) begin
          state_nxt = IDLE;
        end else if (done) begin
          state_nxt      = IDLE;
          last_grant_nxt = GNT_UART;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= GNT_UART;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  assign o_mem_cyc = core_busy | uart_busy;
  assign o_mem_stb = core_busy | uart_busy;
  assign o_mem_we  = (core_busy & i_core_we) | (uart_busy & i_uart_we);
  assign o_mem_adr = core_busy ? i_core_adr[MEM_ADDR_W-1:0] :
                     uart_busy ? i_uart_adr[MEM_ADDR_W-1:0] : '0;
  assign o_mem_dat = core_busy ? i_core_dat :
                     uart_busy ? i_uart_dat : '0;

  // Acks are combinational from the memory ack; gated by rst so a reset in
  // the ack cycle never completes the lost access.
  assign o_core_ack = core_busy & done & ~rst;
  assign o_uart_ack = uart_busy & i_uart_cyc & done & ~rst;

  // Data is only forwarded on a genuine memory ack; a timeout returns zero.
  assign o_core_dat = (o_core_ack & i_mem_ack) ? i_mem_dat : '0;
  assign o_uart_dat = (o_uart_ack & i_mem_ack) ? i_mem_dat : '0;

  assign o_core_stall = (i_core_req & ~o_core_ack) | uart_busy;

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_mem_arbiter
//   Self-checking bench for wb_mem_arbiter: directed scenarios followed by
//   randomized request rounds checked against a transaction-level reference
//   (round-robin winner, shadow memory contents, fixed two-cycle latency).
// ---------------------------------------------------------------------------
module tb_wb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_core_req, i_core_we;
  logic [31:0] i_core_adr, i_core_dat, o_core_dat;
  logic        o_core_ack, o_core_stall;
  logic        i_uart_cyc, i_uart_stb, i_uart_we;
  logic [31:0] i_uart_adr, i_uart_dat, o_uart_dat;
  logic        o_uart_ack;
  logic        o_mem_cyc, o_mem_stb, o_mem_we;
  logic [9:0]  o_mem_adr;
  logic [31:0] o_mem_dat, i_mem_dat;
  logic        i_mem_ack;
  logic        o_err;

  always #5 clk = ~clk;

  wb_mem_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .i_core_req  (i_core_req),
    .i_core_we   (i_core_we),
    .i_core_adr  (i_core_adr),
    .i_core_dat  (i_core_dat),
    .o_core_dat  (o_core_dat),
    .o_core_ack  (o_core_ack),
    .o_core_stall(o_core_stall),
    .i_uart_cyc  (i_uart_cyc),
    .i_uart_stb  (i_uart_stb),
    .i_uart_we   (i_uart_we),
    .i_uart_adr  (i_uart_adr),
    .i_uart_dat  (i_uart_dat),
    .o_uart_dat  (o_uart_dat),
    .o_uart_ack  (o_uart_ack),
    .o_mem_cyc   (o_mem_cyc),
    .o_mem_stb   (o_mem_stb),
    .o_mem_we    (o_mem_we),
    .o_mem_adr   (o_mem_adr),
    .o_mem_dat   (o_mem_dat),
    .i_mem_dat   (i_mem_dat),
    .i_mem_ack   (i_mem_ack),
    .o_err       (o_err)
  );

  function automatic logic [31:0] init_val(input int i);
    return 32'(i) * 32'h9E37_79B9 + 32'h1357_2468;
  endfunction

  // Single-cycle Wishbone memory: acks the cycle after it sees a strobe.
  logic [31:0] mem_array [1024];
  bit          mem_init_done = 1'b0;
  logic        mem_ack;
  logic        mem_hold;

  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 1024; i++) mem_array[i] <= init_val(i);
      mem_init_done <= 1'b1;
    end
    if (rst) begin
      mem_ack <= 1'b0;
    end else begin
      mem_ack <= o_mem_cyc & o_mem_stb & ~mem_ack & ~mem_hold;
      if (o_mem_cyc & o_mem_stb & o_mem_we & mem_ack)
        mem_array[o_mem_adr] <= o_mem_dat;
    end
  end

  assign i_mem_ack = mem_ack;
  assign i_mem_dat = mem_ack ? mem_array[o_mem_adr] : 32'd0;

  // Reference state: shadow memory and who won the last completed access.
  logic [31:0] ref_mem [1024];
  bit          lg_uart;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ":cyc"},   32'(o_mem_cyc),    32'd0);
    check({tag, ":stb"},   32'(o_mem_stb),    32'd0);
    check({tag, ":we"},    32'(o_mem_we),     32'd0);
    check({tag, ":adr"},   32'(o_mem_adr),    32'd0);
    check({tag, ":mdat"},  o_mem_dat,         32'd0);
    check({tag, ":cack"},  32'(o_core_ack),   32'd0);
    check({tag, ":uack"},  32'(o_uart_ack),   32'd0);
    check({tag, ":cdat"},  o_core_dat,        32'd0);
    check({tag, ":udat"},  o_uart_dat,        32'd0);
    check({tag, ":stall"}, 32'(o_core_stall), 32'd0);
    check({tag, ":err"},   32'(o_err),        32'd0);
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    i_core_req = 1'b0; i_uart_cyc = 1'b0; i_uart_stb = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    lg_uart = 1'b1;
    #1;
  endtask

  // Entered in the idle cycle where the master's request is presented.
  // Checks strobe next cycle, ack the cycle after, idle the cycle after that.
  task automatic serve(input string tag, input bit is_core, input bit keep);
    bit          we;
    logic [9:0]  a;
    logic [31:0] wd;
    we = is_core ? i_core_we : i_uart_we;
    a  = is_core ? i_core_adr[9:0] : i_uart_adr[9:0];
    wd = is_core ? i_core_dat : i_uart_dat;
    check({tag, ":idle_cyc"}, 32'(o_mem_cyc), 32'd0);
    @(negedge clk); #1;
    check({tag, ":stb"},        32'(o_mem_stb),  32'd1);
    check({tag, ":we"},         32'(o_mem_we),   32'(we));
    check({tag, ":adr"},        32'(o_mem_adr),  32'(a));
    check({tag, ":wdat"},       o_mem_dat,       wd);
    check({tag, ":early_ack"},  32'({o_core_ack, o_uart_ack}), 32'd0);
    check({tag, ":busy_stall"}, 32'(o_core_stall), 32'd1);
    @(negedge clk); #1;
    check({tag, ":core_ack"},  32'(o_core_ack), 32'(is_core));
    check({tag, ":uart_ack"},  32'(o_uart_ack), 32'(!is_core));
    if (is_core) begin
      check({tag, ":uart_dat0"}, o_uart_dat, 32'd0);
      if (!we) check({tag, ":core_rdat"}, o_core_dat, ref_mem[a]);
    end else begin
      check({tag, ":core_dat0"}, o_core_dat, 32'd0);
      if (!we) check({tag, ":uart_rdat"}, o_uart_dat, ref_mem[a]);
    end
    check({tag, ":ack_stall"}, 32'(o_core_stall), is_core ? 32'd0 : 32'd1);
    if (we) ref_mem[a] = wd;
    lg_uart = !is_core;
    @(negedge clk);
    if (!keep) begin
      if (is_core) i_core_req = 1'b0;
      else begin i_uart_cyc = 1'b0; i_uart_stb = 1'b0; end
    end
    #1;
    check({tag, ":post_cyc"},   32'(o_mem_cyc), 32'd0);
    check({tag, ":post_ack"},   32'({o_core_ack, o_uart_ack}), 32'd0);
    check({tag, ":post_stall"}, 32'(o_core_stall), 32'(i_core_req));
  endtask

  task automatic set_core(input bit we, input logic [31:0] adr, input logic [31:0] dat);
    i_core_req = 1'b1; i_core_we = we; i_core_adr = adr; i_core_dat = dat;
  endtask

  task automatic set_uart(input bit we, input logic [31:0] adr, input logic [31:0] dat);
    i_uart_cyc = 1'b1; i_uart_stb = 1'b1; i_uart_we = we; i_uart_adr = adr; i_uart_dat = dat;
  endtask

  initial begin
    bit          wc, wu, core_first;
    logic [31:0] t;
    int          gap;

    rst = 1'b1; mem_hold = 1'b0; lg_uart = 1'b1;
    i_core_req = 1'b0; i_core_we = 1'b0; i_core_adr = '0; i_core_dat = '0;
    i_uart_cyc = 1'b0; i_uart_stb = 1'b0; i_uart_we = 1'b0; i_uart_adr = '0; i_uart_dat = '0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);

    do_reset();
    check_all_zero("reset");

    // UART write only to the top address; core sees no ack.
    @(negedge clk); set_uart(1'b1, 32'h0000_03FF, 32'hA5A5_A5A5); #1;
    serve("uart_wr", 1'b0, 1'b0);

    // Preload 0x10 through the UART, then core read of it.
    @(negedge clk); set_uart(1'b1, 32'h0000_0010, 32'hDEAD_BEEF); #1;
    serve("uart_pre", 1'b0, 1'b0);
    @(negedge clk); set_core(1'b0, 32'h0000_0010, 32'h0); #1;
    serve("core_rd", 1'b1, 1'b0);
    check("core_rd_value", ref_mem[10'h010], 32'hDEAD_BEEF);
    @(negedge clk); set_uart(1'b0, 32'hFFFF_FFFF, 32'h0); #1;
    serve("uart_rd_3ff", 1'b0, 1'b0);

    // Simultaneous requests right after reset: core first, then UART while
    // the core keeps requesting (and stays stalled), then core again.
    do_reset();
    @(negedge clk);
    set_core(1'b0, 32'h0000_0010, 32'h0);
    set_uart(1'b0, 32'h0000_03FF, 32'h0);
    #1;
    serve("tie1_core", 1'b1, 1'b1);
    serve("tie2_uart", 1'b0, 1'b0);
    serve("tie3_core", 1'b1, 1'b0);

    // UART abort: cyc dropped in the busy cycle before any ack.
    @(negedge clk); set_uart(1'b1, 32'h0000_0020, 32'h1234_5678); #1;
    @(negedge clk); #1;
    check("abort:busy_cyc", 32'(o_mem_cyc), 32'd1);
    i_uart_cyc = 1'b0; i_uart_stb = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      check("abort:cyc", 32'(o_mem_cyc), 32'd0);
      check("abort:uack", 32'(o_uart_ack), 32'd0);
    end

    // Reset in the middle of a core access: everything zero afterwards.
    @(negedge clk); set_core(1'b0, 32'h0000_0030, 32'h0); #1;
    @(negedge clk); #1;
    check("rst_mid:stb", 32'(o_mem_stb), 32'd1);
    rst = 1'b1; i_core_req = 1'b0;
    @(negedge clk); rst = 1'b0; lg_uart = 1'b1; #1;
    check_all_zero("rst_mid");
    @(negedge clk); #1;
    check("rst_mid:no_late_ack", 32'(o_core_ack), 32'd0);

`ifdef WB_ARB_TIMEOUT_EN
    // Memory never acks: the 16th busy cycle acks the core with zero data.
    mem_hold = 1'b1;
    @(negedge clk); set_core(1'b0, 32'h0000_0040, 32'h0); #1;
    for (int k = 1; k < 16; k++) begin
      @(negedge clk); #1;
      check("tmo:wait_ack", 32'(o_core_ack), 32'd0);
      check("tmo:wait_err", 32'(o_err), 32'd0);
    end
    @(negedge clk); #1;
    check("tmo:ack", 32'(o_core_ack), 32'd1);
    check("tmo:dat", o_core_dat, 32'd0);
    check("tmo:err", 32'(o_err), 32'd1);
    @(negedge clk); i_core_req = 1'b0; mem_hold = 1'b0; #1;
    check("tmo:err_pulse", 32'(o_err), 32'd0);
    check("tmo:idle", 32'(o_mem_cyc), 32'd0);
    do_reset();
`endif

    // Randomized rounds against the transaction-level reference.
    for (int r = 0; r < 40; r++) begin
      wc = 1'($urandom_range(0, 1));
      wu = 1'($urandom_range(0, 1));
      if (!wc && !wu) wu = 1'b1;
      @(negedge clk);
      t = $urandom;
      set_core(1'($urandom_range(0, 1)), (t & 32'hFFFF_FC00) | 32'($urandom_range(0, 15)), $urandom);
      i_core_req = wc;
      t = $urandom;
      set_uart(1'($urandom_range(0, 1)), (t & 32'hFFFF_FC00) | 32'($urandom_range(0, 15)), $urandom);
      i_uart_cyc = wu; i_uart_stb = wu;
      #1;
      if (wc && wu) begin
        core_first = lg_uart;
        serve("rr_first", core_first, 1'b0);
        serve("rr_second", !core_first, 1'b0);
      end else begin
        serve("single", wc, 1'b0);
      end
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk); #1;
        check("gap:cyc", 32'(o_mem_cyc), 32'd0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
